// File: rtl/irq_pending_ctrl.sv
// Request capture: sync, edge detect, pending hold, priority valid/ready output.
// Optional IRQ_PENDING_MASK_EN adds a mask input excluding bits from selection.
module irq_pending_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req_in,
`ifdef IRQ_PENDING_MASK_EN
   input  logic [3:0] mask,
`endif
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_code,
   output logic [3:0] pend,
   output logic       ovf,
   input  logic       ovf_clr
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [1:0]                    code_q, code_d;
   logic [3:0]                    pend_q, pend_d;
   logic                          ovf_q, ovf_d;
   logic [SYNC_STAGES-1:0][3:0]   sync_q;
   logic [3:0]                    sdly_q;
   logic [3:0]                    evt_q, evt_d;
   logic [3:0]                    sync;
   logic [3:0]                    evt;
   logic [3:0]                    clr;
   logic [3:0]                    elig;
   logic                          accept;

   function automatic logic [1:0] prio(input logic [3:0] v);
      logic [1:0] r;
      if (v[3])      r = 2'd3;
      else if (v[2]) r = 2'd2;
      else if (v[1]) r = 2'd1;
      else           r = 2'd0;
      return r;
   endfunction

   assign sync = sync_q[SYNC_STAGES-1];

   // Edge result is registered, so pend follows one edge after sdly_q.
   always_comb begin
      evt_d = sync;
      if (EDGE_MODE != 0) evt_d = sync & ~sdly_q;
   end

   assign evt    = evt_q & {4{en}};
   assign accept = (state_q == PRESENT) & out_ready;
   assign clr    = accept ? (4'b0001 << code_q) : 4'b0000;

`ifdef IRQ_PENDING_MASK_EN
   assign elig = pend_q & ~mask;
`else
   assign elig = pend_q;
`endif

   always_comb begin
      pend_d = (pend_q & ~clr) | evt;
      ovf_d  = (|(evt & pend_q & ~clr)) | (ovf_q & ~ovf_clr);
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      unique case (state_q)
         IDLE: begin
            if (|elig) begin
               state_d = PRESENT;
               code_d  = prio(elig);
            end
         end
         PRESENT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         sdly_q  <= '0;
         evt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         code_q  <= 2'd0;
         state_q <= IDLE;
      end else begin
         sync_q[0] <= req_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sdly_q  <= sync;
         evt_q   <= evt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         code_q  <= code_d;
         state_q <= state_d;
      end
   end

   assign out_valid = (state_q == PRESENT);
   assign out_code  = code_q;
   assign pend      = pend_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: vector table, corner sequences, random vs model.
module tb_irq_pending_ctrl;
   localparam int S  = 2;
   localparam int EM = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [3:0] req_in = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] out_code;
   logic [3:0] pend;
   logic       ovf;
   logic       ovf_clr = 1'b0;
`ifdef IRQ_PENDING_MASK_EN
   logic [3:0] mask = '0;
`endif

   int checks = 0;
   int errors = 0;

   irq_pending_ctrl #(.SYNC_STAGES(S), .EDGE_MODE(EM)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req_in(req_in),
`ifdef IRQ_PENDING_MASK_EN
      .mask(mask),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_code(out_code), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr));

   always #5 clk = ~clk;

   // Reference: an event is a rising edge of req seen S+1 edges earlier;
   // the server takes the top eligible bit, shows it, and idles once per code.
   logic [3:0] h [8];
   logic [3:0] m_pend;
   logic       m_busy;
   logic [1:0] m_code;
   logic       m_ovf;

   task automatic model_reset();
      for (int j = 0; j < 8; j++) h[j] = '0;
      m_pend = '0; m_busy = 0; m_code = 0; m_ovf = 0;
   endtask

   task automatic model_step();
      logic [3:0] ev, cl, el;
      for (int j = 7; j > 0; j--) h[j] = h[j-1];
      h[0] = req_in;
      ev = (EM != 0) ? (h[S+1] & ~h[S+2]) : h[S+1];
      if (!en) ev = '0;
      cl = '0;
      if (m_busy && out_ready) cl[m_code] = 1'b1;
      el = m_pend;
`ifdef IRQ_PENDING_MASK_EN
      el = m_pend & ~mask;
`endif
      m_ovf = ((ev & m_pend & ~cl) != 0) || (m_ovf && !ovf_clr);
      if (m_busy) begin
         if (out_ready) m_busy = 0;
      end else if (el != 0) begin
         m_busy = 1;
         for (int b = 0; b < 4; b++) if (el[b]) m_code = 2'(b);
      end
      m_pend = (m_pend & ~cl) | ev;
   endtask

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic e,
                       input logic rdy, input logic c);
      req_in = r; en = e; out_ready = rdy; ovf_clr = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_in = '0; en = 1; out_ready = 0; ovf_clr = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       valid;
      logic [1:0] code;
      logic [3:0] pend;
   } vec_t;

   vec_t tv [19];
   int   n_acc;
   bit   stable;

   initial begin
      tv[0]  = '{4'b0100, 1, 0, 0, 4'b0000};
      tv[1]  = '{4'b0100, 1, 0, 0, 4'b0000};
      tv[2]  = '{4'b0100, 1, 0, 0, 4'b0000};
      tv[3]  = '{4'b0100, 1, 0, 0, 4'b0100};
      tv[4]  = '{4'b0100, 1, 1, 2, 4'b0100};
      tv[5]  = '{4'b0000, 1, 0, 0, 4'b0000};
      tv[6]  = '{4'b0000, 1, 0, 0, 4'b0000};
      tv[7]  = '{4'b0000, 1, 0, 0, 4'b0000};
      tv[8]  = '{4'b0011, 1, 0, 0, 4'b0000};
      tv[9]  = '{4'b0011, 1, 0, 0, 4'b0000};
      tv[10] = '{4'b1011, 1, 0, 0, 4'b0000};
      tv[11] = '{4'b1011, 1, 0, 0, 4'b0011};
      tv[12] = '{4'b0000, 1, 1, 1, 4'b0011};
      tv[13] = '{4'b0000, 1, 0, 0, 4'b1001};
      tv[14] = '{4'b0000, 1, 1, 3, 4'b1001};
      tv[15] = '{4'b0000, 1, 0, 0, 4'b0001};
      tv[16] = '{4'b0000, 1, 1, 0, 4'b0001};
      tv[17] = '{4'b0000, 1, 0, 0, 4'b0000};
      tv[18] = '{4'b0000, 1, 0, 0, 4'b0000};

      do_reset();
      @(negedge clk);
      chk("rst_valid", 8'(out_valid), 8'd0);
      chk("rst_pend", 8'(pend), 8'd0);
      chk("rst_ovf", 8'(ovf), 8'd0);
      chk("rst_code", 8'(out_code), 8'd0);

      // Single request then priority ordering
      for (int i = 0; i < 19; i++) begin
         step(tv[i].req, 1, tv[i].rdy, 0);
         chk($sformatf("tv%0d_valid", i), 8'(out_valid), 8'(tv[i].valid));
         chk($sformatf("tv%0d_pend", i), 8'(pend), 8'(tv[i].pend));
         chk($sformatf("tv%0d_ovf", i), 8'(ovf), 8'd0);
         if (tv[i].valid)
            chk($sformatf("tv%0d_code", i), 8'(out_code), 8'(tv[i].code));
      end

      // Reset while presenting
      do_reset();
      step(4'b1010, 1, 0, 0);
      step(4'b1010, 1, 0, 0);
      repeat (3) step(4'b0000, 1, 0, 0);
      chk("pre_rst_valid", 8'(out_valid), 8'd1);
      chk("pre_rst_code", 8'(out_code), 8'd3);
      chk("pre_rst_pend", 8'(pend), 8'b1010);
      rst_n = 0;
      model_reset();
      #1;
      chk("async_valid", 8'(out_valid), 8'd0);
      chk("async_pend", 8'(pend), 8'd0);
      chk("async_code", 8'(out_code), 8'd0);
      @(negedge clk);
      rst_n = 1;
      stable = 1;
      repeat (8) begin
         step(4'b0000, 1, 1, 0);
         if (out_valid !== 1'b0) stable = 0;
      end
      chk("post_rst_quiet", 8'(stable), 8'd1);

      // Backpressure
      do_reset();
      step(4'b0001, 1, 0, 0);
      step(4'b0001, 1, 0, 0);
      for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step(4'b0000, 1, 0, 0);
      chk("bp_wait_valid", 8'(out_valid), 8'd1);
      stable = 1;
      repeat (10) begin
         step(4'b0000, 1, 0, 0);
         if (out_valid !== 1'b1 || out_code !== 2'd0 || pend !== 4'b0001)
            stable = 0;
      end
      chk("bp_stable", 8'(stable), 8'd1);
      step(4'b0000, 1, 1, 0);
      chk("bp_pend_clr", 8'(pend), 8'd0);
      chk("bp_valid_drop", 8'(out_valid), 8'd0);

      // Overflow
      do_reset();
      step(4'b0010, 1, 0, 0);
      step(4'b0010, 1, 0, 0);
      step(4'b0000, 1, 0, 0);
      step(4'b0000, 1, 0, 0);
      step(4'b0010, 1, 0, 0);
      step(4'b0010, 1, 0, 0);
      repeat (3) step(4'b0000, 1, 0, 0);
      chk("ovf_set", 8'(ovf), 8'd1);
      chk("ovf_pend", 8'(pend), 8'b0010);
      chk("ovf_code", 8'(out_code), 8'd1);
      step(4'b0000, 1, 0, 1);
      chk("ovf_clr", 8'(ovf), 8'd0);
      n_acc = 0;
      repeat (8) begin
         if (out_valid === 1'b1) n_acc++;
         step(4'b0000, 1, 1, 0);
      end
      chk("ovf_served_once", 8'(n_acc), 8'd1);
      chk("ovf_pend_end", 8'(pend), 8'd0);

      // Set/clear collision on bit 2
      do_reset();
      step(4'b0100, 1, 0, 0);
      step(4'b0100, 1, 0, 0);
      repeat (3) step(4'b0000, 1, 0, 0);
      chk("col_first_valid", 8'(out_valid), 8'd1);
      step(4'b0000, 1, 0, 0);
      step(4'b0100, 1, 0, 0);
      step(4'b0100, 1, 0, 0);
      step(4'b0000, 1, 0, 0);
      step(4'b0000, 1, 1, 0);
      chk("col_pend_kept", 8'(pend), 8'b0100);
      chk("col_idle", 8'(out_valid), 8'd0);
      chk("col_no_ovf", 8'(ovf), 8'd0);
      step(4'b0000, 1, 0, 0);
      chk("col_re_valid", 8'(out_valid), 8'd1);
      chk("col_re_code", 8'(out_code), 8'd2);
      step(4'b0000, 1, 1, 0);
      chk("col_pend_end", 8'(pend), 8'd0);

      // Random traffic against the model
      do_reset();
      begin
         logic [3:0] r;
         r = '0;
         for (int i = 0; i < 3000; i++) begin
            r = r ^ 4'($urandom & $urandom);
`ifdef IRQ_PENDING_MASK_EN
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
`endif
            step(r, $urandom_range(0, 9) != 0, 1'($urandom),
                 $urandom_range(0, 9) == 0);
            chk("rnd_valid", 8'(out_valid), 8'(m_busy));
            chk("rnd_pend", 8'(pend), 8'(m_pend));
            chk("rnd_ovf", 8'(ovf), 8'(m_ovf));
            if (m_busy) chk("rnd_code", 8'(out_code), 8'(m_code));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
